multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main controller that sequences a multicycle MIPS datapath: fetch, decode, execute, memory and writeback over several cycles.
- Shares one memory and one ALU across instruction steps.
- Drives every datapath select/enable, decodes Op/Funct, and stalls on a memory ready handshake.
- Keeps a retired-instruction counter for debug and performance.

Parameters:
- CNT_WIDTH, 32, width of the RetireCount counter.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Op  input  6  Instr[31:26] from the instruction register.
- Funct  input  6  Instr[5:0] from the instruction register.
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory has completed the current read/write this cycle.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- PCEn  output  1  PC load enable, equal to PCWrite | (Branch & Zero).
- PCSrc  output  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- ALUControl  output  3  ALU operation code.
- RegDst  output  1  write register select: 1 = rd, 0 = rt.
- MemtoReg  output  1  writeback data select: 1 = memory data, 0 = ALUOut.
- RegWrite  output  1  register file write enable.
- IllegalInstr  output  1  one-cycle pulse on an unsupported opcode or funct.
- RetireCount  output  CNT_WIDTH  count of retired instructions.

Behaviour:
- State register is asynchronously reset to FETCH while Reset = 0.
- While Reset = 0, all write enables are forced to 0: MemWrite, IRWrite, PCEn, RegWrite. IllegalInstr = 0 and RetireCount = 0.
- All other outputs are Moore decodes of the state. Only IRWrite, PCWrite and MemWrite are additionally qualified by MemReady, as listed per state.
- Outputs not listed for a state are 0.
- FETCH: IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUControl = 010, PCSrc = 00.
  - IRWrite and PCWrite assert only when MemReady = 1.
  - Stay in FETCH while MemReady = 0; go to DECODE when MemReady = 1.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUControl = 010 (branch target into ALUOut). Next state by Op:
  - 100011 or 101011 -> MEMADR.
  - 000000 with Funct in {100000, 100010, 100100, 100101, 101010} -> EXECUTE.
  - 000000 with any other Funct -> FETCH, with IllegalInstr pulsed.
  - 000100 -> BRANCH.
  - 001000 -> ADDIEX.
  - 000010 -> JUMP.
  - Any other Op -> FETCH, with IllegalInstr pulsed.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUControl = 010. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: IorD = 1. Hold while MemReady = 0; on MemReady = 1 go to MEMWB.
- MEMWB: RegDst = 0, MemtoReg = 1, RegWrite = 1. Retire, then FETCH.
- MEMWRITE: IorD = 1.
  - MemWrite = MemReady, so exactly one strobe cycle.
  - Hold while MemReady = 0; on MemReady = 1 retire, then FETCH.
- EXECUTE: ALUSrcA = 1, ALUSrcB = 00. ALUControl from Funct:
  - add -> 010, sub -> 110, and -> 000, or -> 001, slt -> 111.
  - Next state ALUWB.
- ALUWB: RegDst = 1, MemtoReg = 0, RegWrite = 1. Retire, then FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUControl = 110, Branch = 1, PCSrc = 01. Retire, then FETCH; taken/not-taken is resolved by PCEn.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUControl = 010. Next state ADDIWB.
- ADDIWB: RegDst = 0, MemtoReg = 0, RegWrite = 1. Retire, then FETCH.
- JUMP: PCSrc = 10, PCWrite = 1. Retire, then FETCH.
- Op and Funct are sampled combinationally in every state. The datapath holds the IR constant outside FETCH.
- RetireCount increments by 1 on the final cycle of each legal instruction. It wraps modulo 2^CNT_WIDTH and never increments on an illegal instruction.
- State encoding: 4 bits. Any unused encoding returns to FETCH on the next edge with all enables 0.
- Reset asserted mid-instruction (including mid-stall) aborts immediately. After release the first edge evaluates FETCH.
- Cycles per instruction with no stall: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each MemReady = 0 cycle adds one.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - State enum constants.
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - Funct constants.
  - ALUControl codes.
  - PCSrc and ALUSrcB select codes.
- One sub-module: alu_decoder, combinational. Maps (ALUOp[1:0], Funct) to ALUControl plus a FunctValid flag. The FSM instantiates it and supplies ALUOp per state.

Test Plan:
- Reset low then high, MemReady = 1, Op = 000000, Funct = 100000 -> FETCH, DECODE, EXECUTE, ALUWB. RegWrite = 1 and RegDst = 1 in cycle 4 only, RetireCount = 1.
- lw (Op = 100011) with MemReady held 0 for 3 cycles in MEMREAD -> IorD = 1 for 4 cycles. RegWrite = 1 and MemtoReg = 1 only in MEMWB; 8 cycles in total.
- sw (Op = 101011) with MemReady = 0,0,1 in MEMWRITE -> MemWrite high exactly 1 cycle (third), no RegWrite.
- beq (Op = 000100), Zero = 1 then repeat with Zero = 0 -> PCEn = 1 with PCSrc = 01 in BRANCH for the first run, PCEn = 0 in BRANCH for the second. RetireCount = 2.
- Op = 111111, then Op = 000000 with Funct = 000111 -> IllegalInstr pulses 1 cycle in DECODE for each, return to FETCH, RetireCount unchanged, no RegWrite or MemWrite.
- Assert Reset low during ADDIEX -> all enables 0 immediately, RetireCount = 0. After release, FETCH asserts IRWrite on the first MemReady = 1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes, ALU operation codes and datapath select codes.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEX   = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALUOp supplied by the FSM to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALURES = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: turns the FSM's ALUOp and the instruction funct field into an
// ALU operation code. FunctValid reports whether Funct is a supported R-type
// funct regardless of ALUOp, so the FSM can reject bad R-types in DECODE.
module alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [5:0] Funct,
   output logic [2:0] ALUControl,
   output logic       FunctValid
);

   logic [2:0] funct_ctrl;

   // Funct lookup, then ALUOp chooses between fixed add/sub and the funct result
   always_comb begin
      funct_ctrl = ALU_ADD;
      FunctValid = 1'b1;
      case (Funct)
         FN_ADD:  funct_ctrl = ALU_ADD;
         FN_SUB:  funct_ctrl = ALU_SUB;
         FN_AND:  funct_ctrl = ALU_AND;
         FN_OR:   funct_ctrl = ALU_OR;
         FN_SLT:  funct_ctrl = ALU_SLT;
         default: FunctValid = 1'b0;
      endcase
      case (ALUOp)
         ALUOP_ADD: ALUControl = ALU_ADD;
         ALUOP_SUB: ALUControl = ALU_SUB;
         default:   ALUControl = funct_ctrl;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main controller for the multicycle MIPS datapath. One FSM steps each
// instruction through fetch/decode/execute/memory/writeback, driving all
// datapath selects and enables, and counts retired instructions.
//
// Memory handshake: the controller holds the address select and strobe
// intent steady in FETCH, MEMREAD and MEMWRITE; MemReady = 1 in a cycle
// means the memory completes that access at the next rising edge. IRWrite,
// PCWrite and MemWrite are qualified by MemReady so each fires exactly once
// per access; with MemReady = 0 the FSM holds its state.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = 32
)(
   input  logic                 CLK,
   input  logic                 Reset,
   input  logic [5:0]           Op,
   input  logic [5:0]           Funct,
   input  logic                 Zero,
   input  logic                 MemReady,
   output logic                 IorD,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 PCEn,
   output logic [1:0]           PCSrc,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [2:0]           ALUControl,
   output logic                 RegDst,
   output logic                 MemtoReg,
   output logic                 RegWrite,
   output logic                 IllegalInstr,
   output logic [CNT_WIDTH-1:0] RetireCount,
   output logic [3:0]           StateDbg
);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

   logic       mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;
   logic       pc_write, branch, retire, use_alu;
   logic [1:0] alu_op;
   logic [2:0] dec_alu_control;
   logic       funct_valid;

   alu_decoder u_alu_decoder (
      .ALUOp      (alu_op),
      .Funct      (Funct),
      .ALUControl (dec_alu_control),
      .FunctValid (funct_valid)
   );

   // State register and retired-instruction counter
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q      <= S_FETCH;
         retire_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // Next-state and Moore decode; unused encodings fall to the all-zero default
   always_comb begin
      state_d       = S_FETCH;
      IorD          = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      pc_write      = 1'b0;
      branch        = 1'b0;
      PCSrc         = PCSRC_ALURES;
      ALUSrcA       = 1'b0;
      ALUSrcB       = SRCB_REG;
      alu_op        = ALUOP_ADD;
      use_alu       = 1'b0;
      RegDst        = 1'b0;
      MemtoReg      = 1'b0;
      reg_write_raw = 1'b0;
      illegal_raw   = 1'b0;
      retire        = 1'b0;
      case (state_q)
         S_FETCH: begin
            ALUSrcB      = SRCB_FOUR;
            use_alu      = 1'b1;
            ir_write_raw = MemReady;
            pc_write     = MemReady;
            state_d      = MemReady ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMMSH;
            use_alu = 1'b1;
            case (Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE: begin
                  if (funct_valid) state_d = S_EXECUTE;
                  else             illegal_raw = 1'b1;
               end
               OP_BEQ:  state_d = S_BRANCH;
               OP_ADDI: state_d = S_ADDIEX;
               OP_J:    state_d = S_JUMP;
               default: illegal_raw = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            use_alu = 1'b1;
            state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            IorD    = 1'b1;
            state_d = MemReady ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            MemtoReg      = 1'b1;
            reg_write_raw = 1'b1;
            retire        = 1'b1;
         end
         S_MEMWRITE: begin
            IorD          = 1'b1;
            mem_write_raw = MemReady;
            retire        = MemReady;
            state_d       = MemReady ? S_FETCH : S_MEMWRITE;
         end
         S_EXECUTE: begin
            ALUSrcA = 1'b1;
            alu_op  = ALUOP_FUNCT;
            use_alu = 1'b1;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegDst        = 1'b1;
            reg_write_raw = 1'b1;
            retire        = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            alu_op  = ALUOP_SUB;
            use_alu = 1'b1;
            branch  = 1'b1;
            PCSrc   = PCSRC_ALUOUT;
            retire  = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            use_alu = 1'b1;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write_raw = 1'b1;
            retire        = 1'b1;
         end
         S_JUMP: begin
            PCSrc    = PCSRC_JUMP;
            pc_write = 1'b1;
            retire   = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Counter next value; wraps naturally at 2^CNT_WIDTH
   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if (retire) retire_cnt_d = retire_cnt_q + CNT_WIDTH'(1);
   end

   // Enables are forced low the moment reset is asserted, even mid-cycle
   assign MemWrite     = Reset & mem_write_raw;
   assign IRWrite      = Reset & ir_write_raw;
   assign PCEn         = Reset & (pc_write | (branch & Zero));
   assign RegWrite     = Reset & reg_write_raw;
   assign IllegalInstr = Reset & illegal_raw;
   assign ALUControl   = use_alu ? dec_alu_control : 3'b000;
   assign RetireCount  = retire_cnt_q;
   assign StateDbg     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Outputs are packed into one 16-bit
// vector {IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, ALUControl,
// RegDst, MemtoReg, RegWrite, IllegalInstr} and compared per cycle with
// hand-written expected vectors. Inputs change 2 time units after a rising
// edge; outputs are sampled 1 unit later.
module tb_multicycle_control;
   import mips_ctrl_pkg::*;

   logic        CLK, Reset, Zero, MemReady;
   logic [5:0]  Op, Funct;
   logic        IorD, MemWrite, IRWrite, PCEn, ALUSrcA, RegDst, MemtoReg, RegWrite, IllegalInstr;
   logic [1:0]  PCSrc, ALUSrcB;
   logic [2:0]  ALUControl;
   logic [31:0] RetireCount;
   logic [3:0]  StateDbg;
   logic [15:0] outs;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_cnt  = 32'd0;

   localparam logic [15:0] V_FETCH       = 16'b0011_00_0_01_010_0000;
   localparam logic [15:0] V_FETCH_STALL = 16'b0000_00_0_01_010_0000;
   localparam logic [15:0] V_DECODE      = 16'b0000_00_0_11_010_0000;
   localparam logic [15:0] V_DECODE_ILL  = 16'b0000_00_0_11_010_0001;
   localparam logic [15:0] V_EXEC_BASE   = 16'b0000_00_1_00_000_0000;
   localparam logic [15:0] V_ALUWB       = 16'b0000_00_0_00_000_1010;
   localparam logic [15:0] V_MEMADR      = 16'b0000_00_1_10_010_0000;
   localparam logic [15:0] V_MEM_WAIT    = 16'b1000_00_0_00_000_0000;
   localparam logic [15:0] V_MEMWB       = 16'b0000_00_0_00_000_0110;
   localparam logic [15:0] V_MEMWR_GO    = 16'b1100_00_0_00_000_0000;
   localparam logic [15:0] V_BR_TAKEN    = 16'b0001_01_1_00_110_0000;
   localparam logic [15:0] V_BR_NOT      = 16'b0000_01_1_00_110_0000;
   localparam logic [15:0] V_ADDIEX      = 16'b0000_00_1_10_010_0000;
   localparam logic [15:0] V_ADDIWB      = 16'b0000_00_0_00_000_0010;
   localparam logic [15:0] V_JUMP        = 16'b0001_10_0_00_000_0000;

   multicycle_control #(.CNT_WIDTH(32)) dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .Op           (Op),
      .Funct        (Funct),
      .Zero         (Zero),
      .MemReady     (MemReady),
      .IorD         (IorD),
      .MemWrite     (MemWrite),
      .IRWrite      (IRWrite),
      .PCEn         (PCEn),
      .PCSrc        (PCSrc),
      .ALUSrcA      (ALUSrcA),
      .ALUSrcB      (ALUSrcB),
      .ALUControl   (ALUControl),
      .RegDst       (RegDst),
      .MemtoReg     (MemtoReg),
      .RegWrite     (RegWrite),
      .IllegalInstr (IllegalInstr),
      .RetireCount  (RetireCount),
      .StateDbg     (StateDbg)
   );

   assign outs = {IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
                  ALUControl, RegDst, MemtoReg, RegWrite, IllegalInstr};

   // Clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic test_reset();
      Reset = 1'b0; MemReady = 1'b1; Op = OP_RTYPE; Funct = FN_ADD; Zero = 1'b0;
      repeat (2) @(posedge CLK);
      #2;
      n_checks++;
      if (outs !== V_FETCH_STALL || StateDbg !== 4'(S_FETCH) || RetireCount !== 32'd0) begin
         n_errors++;
         $display("FAIL reset: outs=%b state=%0d cnt=%0d required outs=%b state=0 cnt=0",
                  outs, StateDbg, RetireCount, V_FETCH_STALL);
      end
      Reset = 1'b1;
   endtask

   task automatic test_rtype_add();
      logic [15:0] ev [4];
      logic [3:0]  es [4];
      ev = '{V_FETCH, V_DECODE, V_EXEC_BASE | 16'h0020, V_ALUWB};
      es = '{S_FETCH, S_DECODE, S_EXECUTE, S_ALUWB};
      Op = OP_RTYPE; Funct = FN_ADD;
      for (int i = 0; i < 4; i++) begin
         MemReady = 1'b1; #1;
         n_checks++;
         if (outs !== ev[i] || StateDbg !== es[i]) begin
            n_errors++;
            $display("FAIL rtype_add cyc%0d: outs=%b state=%0d required outs=%b state=%0d",
                     i, outs, StateDbg, ev[i], es[i]);
         end
         @(posedge CLK); #2;
      end
      exp_cnt++;
      n_checks++;
      if (RetireCount !== exp_cnt) begin
         n_errors++;
         $display("FAIL rtype_add count: got %0d required %0d", RetireCount, exp_cnt);
      end
   endtask

   task automatic test_alu_functs();
      logic [5:0] fn [4];
      logic [2:0] ac [4];
      logic [15:0] ev;
      fn = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
      ac = '{3'b110, 3'b000, 3'b001, 3'b111};
      Op = OP_RTYPE;
      for (int k = 0; k < 4; k++) begin
         Funct = fn[k]; MemReady = 1'b1;
         for (int i = 0; i < 4; i++) begin
            #1;
            if (i == 2) begin
               ev = V_EXEC_BASE | {9'd0, ac[k], 4'd0};
               n_checks++;
               if (outs !== ev || StateDbg !== 4'(S_EXECUTE)) begin
                  n_errors++;
                  $display("FAIL alu_funct %b: outs=%b state=%0d required outs=%b state=%0d",
                           fn[k], outs, StateDbg, ev, S_EXECUTE);
               end
            end
            @(posedge CLK); #2;
         end
         exp_cnt++;
      end
      n_checks++;
      if (RetireCount !== exp_cnt) begin
         n_errors++;
         $display("FAIL alu_functs count: got %0d required %0d", RetireCount, exp_cnt);
      end
   endtask

   task automatic test_lw_stall();
      logic [15:0] ev [8];
      logic [3:0]  es [8];
      logic [7:0]  mr;
      ev = '{V_FETCH, V_DECODE, V_MEMADR, V_MEM_WAIT, V_MEM_WAIT, V_MEM_WAIT, V_MEM_WAIT, V_MEMWB};
      es = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMWB};
      mr = 8'b11_000_111;
      Op = OP_LW; Funct = 6'd0;
      for (int i = 0; i < 8; i++) begin
         MemReady = mr[i]; #1;
         n_checks++;
         if (outs !== ev[i] || StateDbg !== es[i]) begin
            n_errors++;
            $display("FAIL lw cyc%0d: outs=%b state=%0d required outs=%b state=%0d",
                     i, outs, StateDbg, ev[i], es[i]);
         end
         @(posedge CLK); #2;
      end
      exp_cnt++;
      n_checks++;
      if (RetireCount !== exp_cnt || StateDbg !== 4'(S_FETCH)) begin
         n_errors++;
         $display("FAIL lw end: cnt=%0d state=%0d required cnt=%0d state=0", RetireCount, StateDbg, exp_cnt);
      end
   endtask

   task automatic test_sw_stall();
      logic [15:0] ev [6];
      logic [3:0]  es [6];
      logic [5:0]  mr;
      ev = '{V_FETCH, V_DECODE, V_MEMADR, V_MEM_WAIT, V_MEM_WAIT, V_MEMWR_GO};
      es = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_MEMWRITE, S_MEMWRITE};
      mr = 6'b100_111;
      Op = OP_SW; Funct = 6'd0;
      for (int i = 0; i < 6; i++) begin
         MemReady = mr[i]; #1;
         n_checks++;
         if (outs !== ev[i] || StateDbg !== es[i]) begin
            n_errors++;
            $display("FAIL sw cyc%0d: outs=%b state=%0d required outs=%b state=%0d",
                     i, outs, StateDbg, ev[i], es[i]);
         end
         @(posedge CLK); #2;
      end
      exp_cnt++;
      n_checks++;
      if (RetireCount !== exp_cnt || StateDbg !== 4'(S_FETCH)) begin
         n_errors++;
         $display("FAIL sw end: cnt=%0d state=%0d required cnt=%0d state=0", RetireCount, StateDbg, exp_cnt);
      end
   endtask

   task automatic test_beq();
      logic [15:0] ev [3];
      logic [3:0]  es [3];
      es = '{S_FETCH, S_DECODE, S_BRANCH};
      Op = OP_BEQ; Funct = 6'd0; MemReady = 1'b1;
      for (int z = 1; z >= 0; z--) begin
         Zero = (z == 1);
         ev = '{V_FETCH, V_DECODE, (z == 1) ? V_BR_TAKEN : V_BR_NOT};
         for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (outs !== ev[i] || StateDbg !== es[i]) begin
               n_errors++;
               $display("FAIL beq zero=%0d cyc%0d: outs=%b state=%0d required outs=%b state=%0d",
                        z, i, outs, StateDbg, ev[i], es[i]);
            end
            @(posedge CLK); #2;
         end
         exp_cnt++;
      end
      Zero = 1'b0;
      n_checks++;
      if (RetireCount !== exp_cnt) begin
         n_errors++;
         $display("FAIL beq count: got %0d required %0d", RetireCount, exp_cnt);
      end
   endtask

   task automatic test_illegal();
      logic [5:0] ops [2];
      logic [5:0] fns [2];
      ops = '{6'b111111, 6'b000000};
      fns = '{6'b000000, 6'b000111};
      for (int k = 0; k < 2; k++) begin
         Op = ops[k]; Funct = fns[k]; MemReady = 1'b1;
         #1;
         n_checks++;
         if (outs !== V_FETCH) begin
            n_errors++;
            $display("FAIL illegal%0d fetch: outs=%b required %b", k, outs, V_FETCH);
         end
         @(posedge CLK); #2;
         #1;
         n_checks++;
         if (outs !== V_DECODE_ILL || StateDbg !== 4'(S_DECODE)) begin
            n_errors++;
            $display("FAIL illegal%0d decode: outs=%b state=%0d required outs=%b state=1",
                     k, outs, StateDbg, V_DECODE_ILL);
         end
         @(posedge CLK); #2;
         MemReady = 1'b0; #1;
         n_checks++;
         if (outs !== V_FETCH_STALL || StateDbg !== 4'(S_FETCH)) begin
            n_errors++;
            $display("FAIL illegal%0d return: outs=%b state=%0d required outs=%b state=0",
                     k, outs, StateDbg, V_FETCH_STALL);
         end
         @(posedge CLK); #2;
      end
      n_checks++;
      if (RetireCount !== exp_cnt) begin
         n_errors++;
         $display("FAIL illegal count: got %0d required %0d", RetireCount, exp_cnt);
      end
   endtask

   task automatic test_addi_fetch_stall();
      logic [15:0] ev [6];
      logic [3:0]  es [6];
      logic [5:0]  mr;
      ev = '{V_FETCH_STALL, V_FETCH_STALL, V_FETCH, V_DECODE, V_ADDIEX, V_ADDIWB};
      es = '{S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_ADDIEX, S_ADDIWB};
      mr = 6'b111_100;
      Op = OP_ADDI; Funct = 6'd0;
      for (int i = 0; i < 6; i++) begin
         MemReady = mr[i]; #1;
         n_checks++;
         if (outs !== ev[i] || StateDbg !== es[i]) begin
            n_errors++;
            $display("FAIL addi cyc%0d: outs=%b state=%0d required outs=%b state=%0d",
                     i, outs, StateDbg, ev[i], es[i]);
         end
         @(posedge CLK); #2;
      end
      exp_cnt++;
      n_checks++;
      if (RetireCount !== exp_cnt) begin
         n_errors++;
         $display("FAIL addi count: got %0d required %0d", RetireCount, exp_cnt);
      end
   endtask

   task automatic test_jump();
      logic [15:0] ev [3];
      logic [3:0]  es [3];
      ev = '{V_FETCH, V_DECODE, V_JUMP};
      es = '{S_FETCH, S_DECODE, S_JUMP};
      Op = OP_J; Funct = 6'd0; MemReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (outs !== ev[i] || StateDbg !== es[i]) begin
            n_errors++;
            $display("FAIL jump cyc%0d: outs=%b state=%0d required outs=%b state=%0d",
                     i, outs, StateDbg, ev[i], es[i]);
         end
         @(posedge CLK); #2;
      end
      exp_cnt++;
      n_checks++;
      if (RetireCount !== exp_cnt) begin
         n_errors++;
         $display("FAIL jump count: got %0d required %0d", RetireCount, exp_cnt);
      end
   endtask

   task automatic test_reset_mid_addi();
      logic [15:0] ev [3];
      logic [3:0]  es [3];
      Op = OP_ADDI; Funct = 6'd0; MemReady = 1'b1;
      // run up to ADDIEX
      @(posedge CLK); #2;
      @(posedge CLK); #2;
      #1;
      n_checks++;
      if (StateDbg !== 4'(S_ADDIEX)) begin
         n_errors++;
         $display("FAIL rst_mid pre: state=%0d required %0d", StateDbg, S_ADDIEX);
      end
      Reset = 1'b0; #1;
      exp_cnt = 32'd0;
      n_checks++;
      if (outs !== V_FETCH_STALL || StateDbg !== 4'(S_FETCH) || RetireCount !== exp_cnt) begin
         n_errors++;
         $display("FAIL rst_mid abort: outs=%b state=%0d cnt=%0d required outs=%b state=0 cnt=0",
                  outs, StateDbg, RetireCount, V_FETCH_STALL);
      end
      @(posedge CLK); #2;
      Reset = 1'b1; #1;
      n_checks++;
      if (outs !== V_FETCH || StateDbg !== 4'(S_FETCH)) begin
         n_errors++;
         $display("FAIL rst_mid release: outs=%b state=%0d required outs=%b state=0",
                  outs, StateDbg, V_FETCH);
      end
      @(posedge CLK); #2;
      ev = '{V_DECODE, V_ADDIEX, V_ADDIWB};
      es = '{S_DECODE, S_ADDIEX, S_ADDIWB};
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (outs !== ev[i] || StateDbg !== es[i]) begin
            n_errors++;
            $display("FAIL rst_mid cyc%0d: outs=%b state=%0d required outs=%b state=%0d",
                     i, outs, StateDbg, ev[i], es[i]);
         end
         @(posedge CLK); #2;
      end
      exp_cnt++;
      n_checks++;
      if (RetireCount !== exp_cnt) begin
         n_errors++;
         $display("FAIL rst_mid count: got %0d required %0d", RetireCount, exp_cnt);
      end
   endtask

   // Test sequence
   initial begin
      test_reset();
      test_rtype_add();
      test_alu_functs();
      test_lw_stall();
      test_sw_stall();
      test_beq();
      test_illegal();
      test_addi_fetch_stall();
      test_jump();
      test_reset_mid_addi();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
